lsu_byte_master: RTL and testbench

//  Multi-cycle load/store initiator between the core and a byte-wide synchronous data memory.
//  - Accepts one load/store request from the core.
//  - Computes the effective address and range-checks it.
//  - Issues the access to memory one byte per cycle, little-endian.
//  - Assembles and extends load data, then returns a single-cycle response.

---
 rtl/lsu_byte_master.sv | 133 +++++++++++++
 tb/tb_lsu_byte_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_master.sv
// lsu_byte_master: multi-cycle load/store initiator to a byte-wide synchronous data memory.
//    Accepts one request in IDLE, range-checks the effective address, moves one byte per
//    cycle little-endian, then returns a one-cycle response.
//    Ports:
//       clk, rst                     clock, asynchronous active-high reset
//       req_valid/req_ready          request handshake (ready only in IDLE)
//       req_write, req_size          store/load and access size (bits [1:0] give 1/2/4/8 bytes,
//                                    bit 2 selects zero-extension for loads)
//       req_base, req_imm, req_wdata rs1, signed 12-bit offset, rs2 store data
//       resp_valid, resp_fault,      one-cycle completion, fault flag, load result
//       resp_rdata
//       mem_en, mem_we, mem_addr,    byte memory strobe, write enable, address, write byte
//       mem_wdata, mem_rdata         and read byte (valid the cycle after a read strobe)
//    Build option: define LSU_MISALIGN_TRAP_EN to fault any access with ea % N != 0.
module lsu_byte_master #(
   parameter int unsigned DATA_BYTES = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_size,
   input  logic [63:0] req_base,
   input  logic [11:0] req_imm,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_fault,
   output logic [63:0] resp_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] XFER  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] ea_q, ea_d;
   logic        write_q, write_d;
   logic [2:0]  size_q, size_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] data_q, data_d;
   logic        fault_q, fault_d;

   logic [63:0] ea;
   logic [3:0]  nbytes;
   logic [64:0] last_addr;
   logic        bad_size, bad_range, misalign, fault, accept;
   logic [3:0]  n_q;
   logic        last_byte, capture;
   logic [2:0]  rd_idx;
   logic [63:0] mask, ext;
   logic        sign;

   assign ea        = req_base + {{52{req_imm[11]}}, req_imm};
   assign nbytes    = 4'd1 << req_size[1:0];
   // Last byte address in 65 bits so an access straddling 2^64 cannot wrap into range.
   assign last_addr = {1'b0, ea} + 65'(nbytes) - 65'd1;
   assign bad_size  = req_write ? req_size[2] : &req_size;
   assign bad_range = ea >= 64'(DATA_BYTES) || last_addr >= 65'(DATA_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign  = |((nbytes - 4'd1) & {1'b0, ea[2:0]});
`else
   assign misalign  = 1'b0;
`endif
   assign fault     = bad_size || bad_range || misalign;
   assign accept    = req_valid && state_q == IDLE;

   assign n_q       = 4'd1 << size_q[1:0];
   assign last_byte = cnt_q == n_q - 4'd1;
   // Read data trails its strobe by one cycle, so the byte for strobe cnt-1 arrives now.
   assign capture   = !write_q && ((state_q == XFER && cnt_q != 4'd0) || state_q == DRAIN);
   assign rd_idx    = 3'(cnt_q - 4'd1);

   assign state_d = state_q == IDLE  ? (accept ? (fault ? RESP : XFER) : IDLE) :
                    state_q == XFER  ? (last_byte ? DRAIN : XFER) :
                    state_q == DRAIN ? RESP : IDLE;
   assign cnt_d   = accept ? 4'd0 : state_q == XFER ? cnt_q + 4'd1 : cnt_q;
   assign ea_d    = accept ? ea : ea_q;
   assign write_d = accept ? req_write : write_q;
   assign size_d  = accept ? req_size : size_q;
   assign wdata_d = accept ? req_wdata : wdata_q;
   assign fault_d = accept ? fault : fault_q;

   always_comb begin
      data_d = accept ? '0 : data_q;
      if (capture) data_d[{rd_idx, 3'b000} +: 8] = mem_rdata;
   end

   assign mask = size_q[1:0] == 2'd0 ? 64'h0000_0000_0000_00FF :
                 size_q[1:0] == 2'd1 ? 64'h0000_0000_0000_FFFF :
                 size_q[1:0] == 2'd2 ? 64'h0000_0000_FFFF_FFFF : '1;
   // mask ^ (mask >> 1) isolates the most significant bit of the loaded width.
   assign sign = |(data_q & (mask ^ (mask >> 1)));
   assign ext  = (data_q & mask) | ((sign && !size_q[2]) ? ~mask : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ea_q    <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ea_q    <= ea_d;
         write_q <= write_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         fault_q <= fault_d;
      end
   end

   // Outputs decode straight from state so reset removes the strobe immediately.
   assign req_ready  = state_q == IDLE;
   assign mem_en     = state_q == XFER;
   assign mem_we     = mem_en && write_q;
   assign mem_addr   = mem_en ? ea_q + 64'(cnt_q) : '0;
   assign mem_wdata  = mem_we ? 8'(wdata_q >> {cnt_q[2:0], 3'b000}) : '0;
   assign resp_valid = state_q == RESP;
   assign resp_fault = resp_valid && fault_q;
   assign resp_rdata = (resp_valid && !fault_q && !write_q) ? ext : '0;
endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: directed and random load/store traffic against a reference model.
module tb_lsu_byte_master;
   logic        clk, rst;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_size;
   logic [63:0] req_base, req_wdata;
   logic [11:0] req_imm;
   logic        resp_valid, resp_fault;
   logic [63:0] resp_rdata;
   logic        mem_en, mem_we;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   lsu_byte_master dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_base(req_base), .req_imm(req_imm),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_fault(resp_fault),
      .resp_rdata(resp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [512];
   logic [7:0] ref_mem [512];

   always @(posedge clk) begin
      if (mem_en && mem_we && mem_addr < 64'd512) mem[mem_addr[8:0]] <= mem_wdata;
      mem_rdata <= (mem_en && !mem_we && mem_addr < 64'd512) ? mem[mem_addr[8:0]] : 8'($urandom);
   end

   int n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   logic        busy = 1'b0;
   int          cyc, e_n, e_last;
   logic        e_w, e_f;
   logic [63:0] e_ea, e_wd, e_rd;
   int          last_cyc;
   logic        last_fault;
   logic [63:0] last_rdata;

   always @(negedge clk) begin
      if (rst) begin
         busy = 1'b0;
         chk("rst_mem_en", 64'(mem_en), 0);
         chk("rst_mem_we", 64'(mem_we), 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_wdata", 64'(mem_wdata), 0);
         chk("rst_resp_valid", 64'(resp_valid), 0);
         chk("rst_resp_fault", 64'(resp_fault), 0);
         chk("rst_resp_rdata", resp_rdata, 0);
      end else if (!busy) begin
         chk("idle_ready", 64'(req_ready), 1);
         chk("idle_mem_en", 64'(mem_en), 0);
         chk("idle_resp_valid", 64'(resp_valid), 0);
         chk("idle_resp_fault", 64'(resp_fault), 0);
         chk("idle_resp_rdata", resp_rdata, 0);
         if (req_valid) begin
            e_w  = req_write;
            e_wd = req_wdata;
            e_n  = 1 << req_size[1:0];
            e_ea = req_base + {{52{req_imm[11]}}, req_imm};
            e_f  = (req_write ? req_size >= 3'd4 : req_size == 3'd7) || e_ea >= 64'd512 ||
                   e_ea > 64'(512 - e_n);
`ifdef LSU_MISALIGN_TRAP_EN
            if (e_ea % 64'(e_n) != 0) e_f = 1'b1;
`endif
            e_last = e_f ? 1 : e_n + 2;
            e_rd = '0;
            if (!e_f && !e_w)
               for (int i = 0; i < 8; i++)
                  e_rd[8*i +: 8] = i < e_n ? ref_mem[int'(e_ea) + i] :
                     (req_size < 3'd4 && ref_mem[int'(e_ea) + e_n - 1][7]) ? 8'hFF : 8'h00;
            busy = 1'b1;
            cyc = 0;
         end
      end else begin
         cyc++;
         chk("busy_ready", 64'(req_ready), 0);
         chk("mem_en", 64'(mem_en), 64'(!e_f && cyc <= e_n));
         if (!e_f && cyc <= e_n) begin
            chk("mem_addr", mem_addr, e_ea + 64'(cyc - 1));
            chk("mem_we", 64'(mem_we), 64'(e_w));
            if (e_w) begin
               chk("mem_wdata", 64'(mem_wdata), 64'(e_wd[8*(cyc-1) +: 8]));
               ref_mem[int'(e_ea) + cyc - 1] = e_wd[8*(cyc-1) +: 8];
            end
         end
         chk("resp_valid", 64'(resp_valid), 64'(cyc == e_last));
         chk("resp_fault", 64'(resp_fault), 64'(cyc == e_last && e_f));
         chk("resp_rdata", resp_rdata, (cyc == e_last && !e_f && !e_w) ? e_rd : 64'd0);
         if (resp_valid) begin
            last_cyc = cyc;
            last_fault = resp_fault;
            last_rdata = resp_rdata;
         end
         if (cyc == e_last) busy = 1'b0;
      end
   end

   task automatic issue(input logic w, input logic [2:0] sz, input logic [63:0] b,
                        input logic [11:0] im, input logic [63:0] wd);
      last_cyc = -1;
      last_fault = 1'bx;
      last_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      req_write = w; req_size = sz; req_base = b; req_imm = im; req_wdata = wd;
      req_valid = 1'b1;
      for (int t = 0; t < 20 && !busy; t++) begin @(posedge clk); #1; end
      if (!busy) begin
         n_err++;
         $display("FAIL accept_timeout: got busy=0 expected busy=1");
      end
      req_valid = 1'b0;
      req_write = 1'($urandom); req_size = 3'($urandom);
      req_base = {$urandom, $urandom}; req_imm = 12'($urandom); req_wdata = {$urandom, $urandom};
   endtask

   task automatic finish_txn();
      for (int t = 0; t < 40 && busy; t++) begin @(posedge clk); #1; end
      if (busy) begin
         n_err++;
         busy = 1'b0;
         $display("FAIL resp_timeout: got busy=1 expected busy=0");
      end
   endtask

   task automatic run(input logic w, input logic [2:0] sz, input logic [63:0] b,
                      input logic [11:0] im, input logic [63:0] wd);
      issue(w, sz, b, im, wd);
      finish_txn();
   endtask

   initial begin
      logic [7:0]  old [5];
      logic [63:0] ea, se;
      int          diff;
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_base = '0; req_imm = '0; req_wdata = '0;
      for (int i = 0; i < 512; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      run(1'b1, 3'd3, 64'd8, 12'd0, 64'h1122_3344_5566_7788);
      chk("t1_cyc", 64'(last_cyc), 10);
      chk("t1_fault", 64'(last_fault), 0);
      chk("t1_mem8", 64'(mem[8]), 64'h88);
      chk("t1_mem15", 64'(mem[15]), 64'h11);
      run(1'b0, 3'd3, 64'd16, 12'hFF8, 64'd0);
      chk("t2_rdata", last_rdata, 64'h1122_3344_5566_7788);
      chk("t2_cyc", 64'(last_cyc), 10);
      run(1'b1, 3'd0, 64'd20, 12'd0, 64'h80);
      run(1'b0, 3'd0, 64'd20, 12'd0, 64'd0);
      chk("t3_lb", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      chk("t3_lb_cyc", 64'(last_cyc), 3);
      run(1'b0, 3'd4, 64'd20, 12'd0, 64'd0);
      chk("t3_lbu", last_rdata, 64'h80);
      run(1'b0, 3'd2, 64'd508, 12'd0, 64'd0);
      chk("t4_lw508_fault", 64'(last_fault), 0);
      chk("t4_lw508_cyc", 64'(last_cyc), 6);
      run(1'b0, 3'd2, 64'd509, 12'd0, 64'd0);
      chk("t4_lw509_fault", 64'(last_fault), 1);
      chk("t4_lw509_cyc", 64'(last_cyc), 1);
      run(1'b0, 3'd7, 64'd0, 12'd0, 64'd0);
      chk("t4_size7_fault", 64'(last_fault), 1);
      run(1'b1, 3'd4, 64'd0, 12'd0, 64'd0);
      chk("store_size4_fault", 64'(last_fault), 1);
      run(1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 12'h001, 64'd0);
      chk("wrap_to_zero_fault", 64'(last_fault), 0);
      run(1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 12'h000, 64'd0);
      chk("top_addr_fault", 64'(last_fault), 1);

      old[0] = mem[3]; old[1] = mem[4];
      run(1'b1, 3'd1, 64'd3, 12'd0, 64'hBEEF);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("t6_fault", 64'(last_fault), 1);
      chk("t6_cyc", 64'(last_cyc), 1);
      chk("t6_mem3", 64'(mem[3]), 64'(old[0]));
`else
      chk("t6_fault", 64'(last_fault), 0);
      chk("t6_cyc", 64'(last_cyc), 4);
      chk("t6_mem3", 64'(mem[3]), 64'hEF);
      chk("t6_mem4", 64'(mem[4]), 64'hBE);
`endif

      for (int i = 0; i < 5; i++) old[i] = mem[35 + i];
      issue(1'b1, 3'd3, 64'd32, 12'd0, 64'hA1A2_A3A4_A5A6_A7A8);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("t5_mem_en_async", 64'(mem_en), 0);
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("t5_ready", 64'(req_ready), 1);
      chk("t5_mem32", 64'(mem[32]), 64'hA8);
      chk("t5_mem34", 64'(mem[34]), 64'hA6);
      for (int i = 0; i < 5; i++) chk("t5_untouched", 64'(mem[35 + i]), 64'(old[i]));

      for (int n = 0; n < 300; n++) begin
         logic        w;
         logic [2:0]  sz;
         logic [11:0] im;
         w  = 1'($urandom);
         sz = w ? 3'($urandom_range(0, 4)) : 3'($urandom);
         im = 12'($urandom);
         case ($urandom_range(0, 7))
            0: ea = {$urandom, $urandom};
            1: ea = 64'($urandom_range(500, 515));
            2: ea = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            default: ea = 64'($urandom_range(0, 511));
         endcase
         se = {{52{im[11]}}, im};
         run(w, sz, ea - se, im, {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      diff = 0;
      for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) diff++;
      chk("mem_image_diffs", 64'(diff), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
